// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared constants, types and helpers for the FIFO read-side
//             stream controller (output-buffer depth, occupancy/pointer
//             widths, default data and counter widths).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int D_WIDTH_DEF   = 8;
  localparam int CNT_WIDTH_DEF = 16;
  localparam int OBUF_DEPTH    = 3;
  localparam int OCC_W         = $clog2(OBUF_DEPTH + 1);
  localparam int PTR_W         = $clog2(OBUF_DEPTH);

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Circular pointer advance; depth is not a power of two, so wrap explicitly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(OBUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_stream_reader_if
//  Purpose  : valid/ready streaming bus carrying one data word per transfer.
//  Signals  : m_valid - word available (source -> sink)
//             m_data  - word payload    (source -> sink)
//             m_ready - sink accepts    (sink -> source)
//  Modports : master (source side), slave (sink side)
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
  parameter int D_WIDTH = 8
) ();

  logic               m_valid;
  logic [D_WIDTH-1:0] m_data;
  logic               m_ready;

  modport master (output m_valid, output m_data, input  m_ready);
  modport slave  (input  m_valid, input  m_data, output m_ready);

endinterface : fifo_stream_reader_if
`default_nettype wire

// File: rtl/stream_obuf.sv
`default_nettype none
// ============================================================================
//  Module   : stream_obuf
//  Purpose  : 3-entry circular output buffer with head/tail pointers and
//             occupancy. Head entry is presented combinationally; it reads
//             as zero when the buffer is empty so no stale word is visible.
//  Ports    : clk, n_rst     - clock, async active-low reset
//             i_push/i_push_data - write a word at the tail
//             i_pop          - retire the head word
//             i_clear        - synchronous discard of all contents
//             o_head_data    - head word (0 when empty)
//             o_occ          - number of stored words (0..3)
//  Revision : 1.0 - initial release
// ============================================================================
module stream_obuf
  import fifo_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  wire logic               clk,
  input  wire logic               n_rst,
  input  wire logic               i_push,
  input  wire logic [D_WIDTH-1:0] i_push_data,
  input  wire logic               i_pop,
  input  wire logic               i_clear,
  output logic      [D_WIDTH-1:0] o_head_data,
  output occ_t                    o_occ
);

  logic [D_WIDTH-1:0] r_mem [OBUF_DEPTH];
  ptr_t               r_head;
  ptr_t               r_tail;
  occ_t               r_occ;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (i_pop) begin
        r_head <= ptr_inc(r_head);
      end
      r_occ <= r_occ + occ_t'(i_push) - occ_t'(i_pop);
    end
  end

  assign o_head_data = (r_occ != '0) ? r_mem[r_head] : '0;
  assign o_occ       = r_occ;

  // The issue logic upstream must never let a word arrive into a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst)
    !(i_push && !i_pop && (r_occ == occ_t'(OBUF_DEPTH))));

endmodule : stream_obuf
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_stream_reader
//  Purpose  : Read-side controller for the synchronous FIFO. Pops words via
//             isEmpty/r_en/r_data (1-cycle read latency), buffers them in a
//             3-entry output buffer and presents them on a valid/ready
//             stream. Counts delivered words and supports a synchronous flush.
//  Ports    : clk, n_rst - clock, async active-low reset
//             isEmpty    - FIFO empty flag
//             r_en       - FIFO pop request
//             r_data     - FIFO read data (valid the cycle after r_en)
//             m_if       - stream master (m_valid, m_data, m_ready)
//             flush      - discard buffered and in-flight data
//             rd_count   - delivered-word count, wraps
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int D_WIDTH   = D_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  wire logic                 clk,
  input  wire logic                 n_rst,
  input  wire logic                 isEmpty,
  output logic                      r_en,
  input  wire logic [D_WIDTH-1:0]   r_data,
  fifo_stream_reader_if.master      m_if,
  input  wire logic                 flush,
  output logic      [CNT_WIDTH-1:0] rd_count
);

  localparam logic [OCC_W:0] c_DEPTH = (OCC_W + 1)'(OBUF_DEPTH);

  occ_t               w_occ;
  logic [D_WIDTH-1:0] w_head_data;
  logic [OCC_W:0]     w_pending;
  logic               w_issue;
  logic               w_capture;
  logic               w_transfer;

  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_rd_count;

  // Reserve a buffer slot for every word already requested so a returning
  // word always has room; this is what lets r_en ignore m_ready entirely.
  assign w_pending  = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight};
  // n_rst gates the request so r_en is low for the whole reset interval.
  assign w_issue    = n_rst && !isEmpty && !flush && (w_pending < c_DEPTH);
  assign w_capture  = r_inflight && !flush;
  assign w_transfer = m_if.m_valid && m_if.m_ready;

  assign r_en         = w_issue;
  assign m_if.m_valid = (w_occ != '0);
  assign m_if.m_data  = w_head_data;
  assign rd_count     = r_rd_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_inflight <= 1'b0;
      r_rd_count <= '0;
    end else begin
      // w_issue is already low during flush, so this also drops inflight.
      r_inflight <= w_issue;
      // A transfer in the flush cycle was accepted downstream: still count it.
      if (w_transfer) begin
        r_rd_count <= r_rd_count + CNT_WIDTH'(1);
      end
    end
  end

  stream_obuf #(
    .D_WIDTH (D_WIDTH)
  ) u_obuf (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_push      (w_capture),
    .i_push_data (r_data),
    .i_pop       (w_transfer),
    .i_clear     (flush),
    .o_head_data (w_head_data),
    .o_occ       (w_occ)
  );

endmodule : fifo_stream_reader
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_stream_reader
//  Purpose  : Self-checking bench for fifo_stream_reader: a FIFO read-port
//             model feeds two instances (16-bit and 4-bit counters) with
//             identical stimulus; table-driven streaming/backpressure vectors
//             plus directed flush, counter-wrap and async-reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  typedef struct {
    logic       ready;
    logic       flush;
    logic       exp_ren;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        isEmpty;
  logic        r_en;
  logic        r_en4;
  logic [7:0]  r_data = 8'h00;
  logic        flush;
  logic [15:0] rd_count;
  logic [3:0]  rd_count4;

  int checks   = 0;
  int failures = 0;

  fifo_stream_reader_if #(.D_WIDTH(8)) s_if  ();
  fifo_stream_reader_if #(.D_WIDTH(8)) s4_if ();
  assign s4_if.m_ready = s_if.m_ready;

  fifo_stream_reader #(.D_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .isEmpty  (isEmpty),
    .r_en     (r_en),
    .r_data   (r_data),
    .m_if     (s_if),
    .flush    (flush),
    .rd_count (rd_count)
  );

  fifo_stream_reader #(.D_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk      (clk),
    .n_rst    (n_rst),
    .isEmpty  (isEmpty),
    .r_en     (r_en4),
    .r_data   (r_data),
    .m_if     (s4_if),
    .flush    (flush),
    .rd_count (rd_count4)
  );

  always #5 clk = ~clk;

  // FIFO read-port model: one-cycle read latency, not reset by n_rst.
  logic [7:0] fmem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign isEmpty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (r_en) begin
      checks++;
      if (isEmpty) begin
        failures++;
        $display("FAIL fifo_underflow: r_en=1 while isEmpty=1 at %0t", $time);
      end else begin
        r_data <= fmem[rd_ptr % 256];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr % 256] = first + 8'(i);
      wr_ptr++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    flush = 1'b0;
    s_if.m_ready = 1'b0;
    tick();
    tick();
    #2 n_rst = 1'b1;
    tick();
  endtask

  vec_t vecs [23];

  initial begin
    // Streaming: 8 words, m_ready high (rows 0..10).
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h12};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h13};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h14};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h15};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h16};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h17};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h18};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    // Backpressure: 5 words, m_ready low 6 cycles then high (rows 11..22).
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h12};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h13};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h14};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h15};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    n_rst = 1'b0;
    flush = 1'b0;
    s_if.m_ready = 1'b0;
    #3;
    chk("reset_r_en", 32'(r_en), 32'h0);
    chk("reset_valid", 32'(s_if.m_valid), 32'h0);
    chk("reset_data", 32'(s_if.m_data), 32'h0);
    chk("reset_count", 32'(rd_count), 32'h0);
    do_reset();

    // Idle with FIFO empty.
    for (int i = 0; i < 10; i++) begin
      chk("idle_r_en", 32'(r_en), 32'h0);
      chk("idle_valid", 32'(s_if.m_valid), 32'h0);
      chk("idle_count", 32'(rd_count), 32'h0);
      tick();
    end

    // Table: streaming then backpressure.
    load(8'h11, 8);
    for (int i = 0; i < 23; i++) begin
      if (i == 11) begin
        chk("stream_count", 32'(rd_count), 32'd8);
        load(8'h11, 5);
      end
      s_if.m_ready = vecs[i].ready;
      flush        = vecs[i].flush;
      #1;
      chk($sformatf("vec%0d_r_en", i), 32'(r_en), 32'(vecs[i].exp_ren));
      chk($sformatf("vec%0d_valid", i), 32'(s_if.m_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_data", i), 32'(s_if.m_data), 32'(vecs[i].exp_data));
      tick();
    end
    chk("bp_count", 32'(rd_count), 32'd13);

    // Flush with occ=2 and a pop in flight, flush held for 3 cycles.
    s_if.m_ready = 1'b0;
    load(8'h21, 4);
    tick(); tick(); tick();
    chk("fl_pre_valid", 32'(s_if.m_valid), 32'h1);
    chk("fl_pre_data", 32'(s_if.m_data), 32'h21);
    flush = 1'b1;
    #1;
    chk("fl_r_en_T", 32'(r_en), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("fl_hold_valid", 32'(s_if.m_valid), 32'h0);
      chk("fl_hold_data", 32'(s_if.m_data), 32'h0);
      chk("fl_hold_r_en", 32'(r_en), 32'h0);
    end
    tick();
    flush = 1'b0;
    s_if.m_ready = 1'b1;
    #1;
    chk("fl_resume_r_en", 32'(r_en), 32'h1);
    chk("fl_resume_valid", 32'(s_if.m_valid), 32'h0);
    tick();
    chk("fl_c7_valid", 32'(s_if.m_valid), 32'h0);
    tick();
    chk("fl_next_valid", 32'(s_if.m_valid), 32'h1);
    chk("fl_next_data", 32'(s_if.m_data), 32'h24);
    tick();
    chk("fl_end_valid", 32'(s_if.m_valid), 32'h0);
    chk("fl_count", 32'(rd_count), 32'd14);

    // Counter wrap on the 4-bit instance: 17 transfers.
    do_reset();
    s_if.m_ready = 1'b1;
    load(8'h40, 17);
    for (int c = 0; c <= 19; c++) begin
      if (c == 10) chk("wrap_data_mid", 32'(s_if.m_data), 32'h48);
      if (c == 17) chk("wrap_cnt15", 32'(rd_count4), 32'd15);
      if (c == 18) chk("wrap_cnt0", 32'(rd_count4), 32'd0);
      if (c == 19) begin
        chk("wrap_cnt1", 32'(rd_count4), 32'd1);
        chk("wrap_cnt16b", 32'(rd_count), 32'd17);
        chk("wrap_idle_valid", 32'(s_if.m_valid), 32'h0);
      end
      tick();
    end

    // Asynchronous reset mid-stream with occ=2 and a pop in flight.
    do_reset();
    load(8'h31, 5);
    tick(); tick(); tick();
    chk("ar_pre_valid", 32'(s_if.m_valid), 32'h1);
    #3 n_rst = 1'b0;
    #1;
    chk("ar_valid", 32'(s_if.m_valid), 32'h0);
    chk("ar_data", 32'(s_if.m_data), 32'h0);
    chk("ar_r_en", 32'(r_en), 32'h0);
    chk("ar_count", 32'(rd_count), 32'h0);
    #1 n_rst = 1'b1;
    s_if.m_ready = 1'b1;
    #1;
    chk("ar_rel_r_en", 32'(r_en), 32'h1);
    tick();
    chk("ar_e1_valid", 32'(s_if.m_valid), 32'h0);
    tick();
    chk("ar_e2_valid", 32'(s_if.m_valid), 32'h1);
    chk("ar_e2_data", 32'(s_if.m_data), 32'h34);
    tick();
    chk("ar_e3_data", 32'(s_if.m_data), 32'h35);
    tick();
    chk("ar_e4_valid", 32'(s_if.m_valid), 32'h0);
    chk("ar_e4_count", 32'(rd_count), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_fifo_stream_reader
`default_nettype wire
